// File: rtl/grant_hold_ctrl.sv
// Locks the upstream priority arbiter's one-hot grant to its winner until done, request
// withdrawal or a hold timeout, then forces a one-cycle dead time before the next grant.
`timescale 1ns / 1ps

module grant_hold_ctrl #(
  parameter int unsigned N       = 4,
  parameter int unsigned MaxHold = 16,
  localparam int unsigned IdW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   req_i,
  input  logic [N-1:0]   arb_gnt_i,
  input  logic           done_i,
  output logic [N-1:0]   gnt_o,
  output logic           gnt_valid_o,
  output logic [IdW-1:0] gnt_id_o,
  output logic           timeout_o,
  output logic           proto_err_o
);

  localparam int unsigned   CntW    = $clog2(MaxHold + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MaxHold - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StRelease = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [N-1:0]    gnt_q, gnt_d;
  logic            valid_q, valid_d;
  logic [IdW-1:0]  gnt_id_q, gnt_id_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            proto_err_q, proto_err_d;

  // Upstream grant qualification
  logic           arb_any;
  logic           arb_onehot;
  logic           arb_hit;
  logic           arb_legal;
  logic [IdW-1:0] arb_idx;

  assign arb_any    = |arb_gnt_i;
  assign arb_onehot = arb_any && ((arb_gnt_i & (arb_gnt_i - N'(1))) == '0);
  assign arb_hit    = |(arb_gnt_i & req_i);
  assign arb_legal  = arb_onehot && arb_hit;

  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (arb_gnt_i[i]) begin
        arb_idx = IdW'(i);
      end
    end
  end

  // Release conditions while a grant is held
  logic owner_req;
  logic hold_expired;
  logic rel_any;

  assign owner_req    = req_i[gnt_id_q];
  assign hold_expired = (cnt_q == CntLast);
  assign rel_any      = done_i || !owner_req || hold_expired;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (arb_legal) begin
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (rel_any) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    gnt_d       = gnt_q;
    valid_d     = valid_q;
    gnt_id_d    = gnt_id_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    proto_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_legal) begin
          gnt_d    = arb_gnt_i;
          valid_d  = 1'b1;
          gnt_id_d = arb_idx;
          cnt_d    = '0;
        end else if (arb_any) begin
          proto_err_d = 1'b1;
        end
      end
      StGrant: begin
        if (rel_any) begin
          gnt_d   = '0;
          valid_d = 1'b0;
          // Timeout only when expiry is the sole reason for release
          timeout_d = !done_i && owner_req && hold_expired;
        end else if (cnt_q != CntLast) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        gnt_d   = '0;
        valid_d = 1'b0;
      end
      default: begin
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_q       <= '0;
      valid_q     <= 1'b0;
      gnt_id_q    <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      valid_q     <= valid_d;
      gnt_id_q    <= gnt_id_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = valid_q;
  assign gnt_id_o    = gnt_id_q;
  assign timeout_o   = timeout_q;
  assign proto_err_o = proto_err_q;

  // Structural invariants of the registered outputs
  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_q));
  a_valid_match : assert property (@(posedge clk_i) disable iff (!rst_ni) valid_q == |gnt_q);
  a_pulse_excl  : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(timeout_q && proto_err_q));

endmodule

// File: tb/tb_grant_hold_ctrl.sv
// Scoreboard bench for grant_hold_ctrl: each stimulus row queues its expected outputs,
// which are popped and compared one cycle later.
`timescale 1ns / 1ps

module tb_grant_hold_ctrl;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] arb;
    logic       done;
    logic [8:0] exp;
  } row_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] arb_gnt;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout;
  logic       proto_err;
  logic [8:0] obs;

  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  grant_hold_ctrl #(
    .N      (4),
    .MaxHold(16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .arb_gnt_i  (arb_gnt),
    .done_i     (done),
    .gnt_o      (gnt),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id),
    .timeout_o  (timeout),
    .proto_err_o(proto_err)
  );

  assign obs = {gnt, gnt_valid, gnt_id, timeout, proto_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] e(input logic [3:0] g, input logic v, input logic [1:0] id,
                                   input logic to, input logic pe);
    return {g, v, id, to, pe};
  endfunction

  function automatic row_t row(input logic [3:0] r, input logic [3:0] a, input logic d,
                               input logic [8:0] x);
    return {r, a, d, x};
  endfunction

  task automatic test_reset();
    logic [8:0] x;
    rst_n   = 1'b0;
    req     = '0;
    arb_gnt = '0;
    done    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 9'b0) begin
      failures++;
      $display("FAIL reset_hold: got %b expected %b", obs, 9'b0);
    end
    rst_n = 1'b1;
    exp_q.push_back(e(4'b0000, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    checks++;
    if (obs !== x) begin
      failures++;
      $display("FAIL reset_idle: got %b expected %b", obs, x);
    end
  endtask

  task automatic test_basic_done();
    row_t rows[$];
    logic [8:0] x;
    rows.push_back(row(4'b0101, 4'b0001, 0, e(4'b0001, 1, 0, 0, 0)));
    rows.push_back(row(4'b0101, 4'b0001, 1, e(4'b0000, 0, 0, 0, 0)));
    rows.push_back(row(4'b0101, 4'b0001, 0, e(4'b0000, 0, 0, 0, 0)));
    rows.push_back(row(4'b0101, 4'b0001, 1, e(4'b0001, 1, 0, 0, 0)));  // done ignored in idle
    rows.push_back(row(4'b0101, 4'b0001, 1, e(4'b0000, 0, 0, 0, 0)));
    rows.push_back(row(4'b0000, 4'b0000, 0, e(4'b0000, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      req = rows[i].req; arb_gnt = rows[i].arb; done = rows[i].done;
      exp_q.push_back(rows[i].exp);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        failures++;
        $display("FAIL basic_done row %0d: got %b expected %b", i, obs, x);
      end
    end
  endtask

  task automatic test_no_preempt();
    row_t rows[$];
    logic [8:0] x;
    rows.push_back(row(4'b0100, 4'b0100, 0, e(4'b0100, 1, 2, 0, 0)));
    rows.push_back(row(4'b0101, 4'b0001, 0, e(4'b0100, 1, 2, 0, 0)));
    rows.push_back(row(4'b0101, 4'b0001, 0, e(4'b0100, 1, 2, 0, 0)));
    rows.push_back(row(4'b0101, 4'b0001, 1, e(4'b0000, 0, 2, 0, 0)));
    rows.push_back(row(4'b0101, 4'b0001, 0, e(4'b0000, 0, 2, 0, 0)));
    rows.push_back(row(4'b0101, 4'b0001, 0, e(4'b0001, 1, 0, 0, 0)));
    rows.push_back(row(4'b0101, 4'b0001, 1, e(4'b0000, 0, 0, 0, 0)));
    rows.push_back(row(4'b0000, 4'b0000, 0, e(4'b0000, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      req = rows[i].req; arb_gnt = rows[i].arb; done = rows[i].done;
      exp_q.push_back(rows[i].exp);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        failures++;
        $display("FAIL no_preempt row %0d: got %b expected %b", i, obs, x);
      end
    end
  endtask

  task automatic test_timeout();
    row_t rows[$];
    logic [8:0] x;
    rows.push_back(row(4'b1000, 4'b1000, 0, e(4'b1000, 1, 3, 0, 0)));
    for (int k = 1; k < 16; k++) begin
      rows.push_back(row(4'b1000, 4'b1000, 0, e(4'b1000, 1, 3, 0, 0)));
    end
    rows.push_back(row(4'b1000, 4'b1000, 0, e(4'b0000, 0, 3, 1, 0)));
    rows.push_back(row(4'b1000, 4'b1000, 0, e(4'b0000, 0, 3, 0, 0)));
    rows.push_back(row(4'b1000, 4'b1000, 0, e(4'b1000, 1, 3, 0, 0)));
    rows.push_back(row(4'b1000, 4'b1000, 1, e(4'b0000, 0, 3, 0, 0)));
    rows.push_back(row(4'b0000, 4'b0000, 0, e(4'b0000, 0, 3, 0, 0)));
    foreach (rows[i]) begin
      req = rows[i].req; arb_gnt = rows[i].arb; done = rows[i].done;
      exp_q.push_back(rows[i].exp);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        failures++;
        $display("FAIL timeout row %0d: got %b expected %b", i, obs, x);
      end
    end
  endtask

  task automatic test_done_at_expiry();
    row_t rows[$];
    logic [8:0] x;
    rows.push_back(row(4'b0001, 4'b0001, 0, e(4'b0001, 1, 0, 0, 0)));
    for (int k = 1; k < 16; k++) begin
      rows.push_back(row(4'b0001, 4'b0001, 0, e(4'b0001, 1, 0, 0, 0)));
    end
    rows.push_back(row(4'b0001, 4'b0001, 1, e(4'b0000, 0, 0, 0, 0)));
    rows.push_back(row(4'b0000, 4'b0000, 0, e(4'b0000, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      req = rows[i].req; arb_gnt = rows[i].arb; done = rows[i].done;
      exp_q.push_back(rows[i].exp);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        failures++;
        $display("FAIL done_at_expiry row %0d: got %b expected %b", i, obs, x);
      end
    end
  endtask

  task automatic test_proto_withdraw();
    row_t rows[$];
    logic [8:0] x;
    rows.push_back(row(4'b0001, 4'b0011, 0, e(4'b0000, 0, 0, 0, 1)));
    rows.push_back(row(4'b0001, 4'b0000, 0, e(4'b0000, 0, 0, 0, 0)));
    rows.push_back(row(4'b0001, 4'b0010, 0, e(4'b0000, 0, 0, 0, 1)));
    rows.push_back(row(4'b0001, 4'b0000, 0, e(4'b0000, 0, 0, 0, 0)));
    rows.push_back(row(4'b0010, 4'b0010, 0, e(4'b0010, 1, 1, 0, 0)));
    rows.push_back(row(4'b0010, 4'b0011, 0, e(4'b0010, 1, 1, 0, 0)));  // illegal arb ignored
    rows.push_back(row(4'b0000, 4'b0000, 0, e(4'b0000, 0, 1, 0, 0)));
    rows.push_back(row(4'b0001, 4'b0011, 0, e(4'b0000, 0, 1, 0, 0)));  // release cycle
    rows.push_back(row(4'b0000, 4'b0000, 0, e(4'b0000, 0, 1, 0, 0)));
    foreach (rows[i]) begin
      req = rows[i].req; arb_gnt = rows[i].arb; done = rows[i].done;
      exp_q.push_back(rows[i].exp);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        failures++;
        $display("FAIL proto_withdraw row %0d: got %b expected %b", i, obs, x);
      end
    end
  endtask

  task automatic test_async_reset();
    row_t rows[$];
    logic [8:0] x;
    req = 4'b0100; arb_gnt = 4'b0100; done = 1'b0;
    exp_q.push_back(e(4'b0100, 1, 2, 0, 0));
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    checks++;
    if (obs !== x) begin
      failures++;
      $display("FAIL async_pre_grant: got %b expected %b", obs, x);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 9'b0) begin
      failures++;
      $display("FAIL async_clear: got %b expected %b", obs, 9'b0);
    end
    req = 4'b0001; arb_gnt = 4'b0001;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 9'b0) begin
      failures++;
      $display("FAIL async_held: got %b expected %b", obs, 9'b0);
    end
    #3 rst_n = 1'b1;
    rows.push_back(row(4'b0001, 4'b0001, 0, e(4'b0001, 1, 0, 0, 0)));
    rows.push_back(row(4'b0001, 4'b0001, 1, e(4'b0000, 0, 0, 0, 0)));
    rows.push_back(row(4'b0000, 4'b0000, 0, e(4'b0000, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      req = rows[i].req; arb_gnt = rows[i].arb; done = rows[i].done;
      exp_q.push_back(rows[i].exp);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        failures++;
        $display("FAIL async_regrant row %0d: got %b expected %b", i, obs, x);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_done();
    test_no_preempt();
    test_timeout();
    test_done_at_expiry();
    test_proto_withdraw();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grant_hold_ctrl.md
Name: grant_hold_ctrl

Overview:
- Sequential stage directly downstream of the fixed-priority (LSB-wins) combinational arbiter.
- Takes that arbiter's one-hot grant vector, registers it, and locks ownership to the winner until the transaction ends. A transaction ends on a done pulse, on request withdrawal, or on a hold timeout.
- Provides registered grant, a binary owner id and status pulses to the shared-resource mux.
- Prevents the combinational arbiter from switching owners mid-transaction when a higher-priority request arrives.

Parameters:
- N, 4, number of requesters; width of req/arb_gnt/gnt.
- MAX_HOLD, 16, maximum cycles a grant is held without done; legal range is 2 or more.
- ID_W, $clog2(N), width of gnt_id; derived, never overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  raw request lines, the same vector that feeds the upstream arbiter.
- arb_gnt  input  N  one-hot combinational grant from the upstream priority arbiter.
- done  input  1  owner signals transaction complete; single-cycle pulse.
- gnt  output  N  registered, locked one-hot grant.
- gnt_valid  output  1  high while a grant is held.
- gnt_id  output  ID_W  binary index of the set bit in gnt.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.
- proto_err  output  1  one-cycle pulse when arb_gnt is illegal while sampled in IDLE.

Behaviour:
- Reset: already decided as one clock with asynchronous, active-low reset.
  - rst_n low clears immediately, independent of clk: gnt=0, gnt_valid=0, gnt_id=0, timeout=0, proto_err=0, hold_cnt=0, state=IDLE.
  - Reset mid-grant drops the grant with no timeout pulse.
  - After rst_n deasserts, the first grant can occur at the first rising edge.
- Counter: hold_cnt is $clog2(MAX_HOLD+1) bits wide and never wraps.
- State IDLE (entry cycle of each grant and first cycle after reset):
  - arb_gnt is legal when it is exactly one-hot and (arb_gnt & req) != 0.
  - Legal arb_gnt: at the edge, gnt<=arb_gnt, gnt_valid<=1, gnt_id<=index, hold_cnt<=0, go to GRANT. Request-to-grant latency is 1 edge.
  - arb_gnt == 0: stay in IDLE, outputs unchanged.
  - arb_gnt nonzero but illegal (multi-hot, or bit not in req): stay in IDLE, proto_err=1 for one cycle.
  - done is ignored in IDLE.
- State GRANT:
  - hold_cnt increments every cycle.
  - arb_gnt is ignored: a higher-priority request never preempts.
  - Release conditions, evaluated each edge in this priority order:
    1. done=1: release, timeout stays 0.
    2. req[gnt_id]=0 (owner withdrew): release, timeout stays 0.
    3. hold_cnt == MAX_HOLD-1: release, timeout=1 for one cycle.
  - Done and expiry in the same cycle: done wins, no timeout.
  - On release: gnt<=0, gnt_valid<=0, go to RELEASE. gnt_id holds its last value.
  - A grant is therefore held for at most MAX_HOLD cycles.
- State RELEASE:
  - Lasts exactly one cycle; unconditional transition to IDLE.
  - arb_gnt, done and req are ignored.
  - Guarantees at least 2 cycles with gnt_valid=0 between consecutive grants, giving the downstream mux a dead cycle.
- Output invariants:
  - timeout and proto_err are registered single-cycle pulses.
  - gnt is always zero or one-hot.
  - gnt_valid == |gnt.

Test Plan:
- Reset, then req=4'b0101, arb_gnt=4'b0001 -> after 1 edge gnt=0001, gnt_valid=1, gnt_id=0. Then done pulse -> gnt=0000 next edge; with req still 0101, regrant 0001 two edges later.
- Owner 2 granted (req=0100, arb_gnt=0100). req changes to 0101, arb_gnt to 0001 -> gnt stays 0100, gnt_id=2 (no preemption). done -> release, then gnt=0001.
- req=1000 held, done never asserted, MAX_HOLD=16 -> gnt=1000 for exactly 16 cycles, timeout=1 on the release edge, then 2 idle cycles, then regrant 1000.
- done asserted on the same cycle hold_cnt reaches 15 -> release with timeout=0.
- In IDLE, arb_gnt=0011, then arb_gnt=0010 with req=0001 -> proto_err pulses once each time, no grant. Owner 1 granted, then req[1] drops to 0 -> released next edge, timeout=0.
- rst_n pulled low asynchronously mid-grant (between edges) -> gnt=0, gnt_valid=0 immediately. After release of rst_n with req=0001, arb_gnt=0001 -> grant at the first edge.
